// File: rtl/uart_tx_arbiter_if.sv
// Request and UART-side signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the UART.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int MSG_W   = 40,
  parameter int DROP_W  = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*MSG_W-1:0] req_msg;
  logic [NUM_REQ-1:0]       req_err;
  logic [NUM_REQ-1:0]       req_ack;
  logic                     uart_out_ready;
  logic [MSG_W-1:0]         uart_out_msg;
  logic                     uart_out_req;
  logic                     halted;
  logic [DROP_W-1:0]        drop_count;

  modport master (
    output req_valid, req_msg, req_err, uart_out_ready,
    input  req_ack, uart_out_msg, uart_out_req, halted, drop_count
  );

  modport slave (
    input  req_valid, req_msg, req_err, uart_out_ready,
    output req_ack, uart_out_msg, uart_out_req, halted, drop_count
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART message path among NUM_REQ sources. Error messages win arbitration.
// The first error message that is sent freezes the path in HALT, where later messages are dropped.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int MSG_W   = 40,
  parameter int DROP_W  = 8
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, HALT = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   last_grant_q, last_grant_d;
  logic               cur_err_q, cur_err_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [DROP_W-1:0]  drop_q, drop_d;

  logic               err_found_s, rr_found_s, low_found_s, win_found_s;
  logic [PTR_W-1:0]   err_idx_s, rr_idx_s, low_idx_s, win_idx_s;
  int                 rr_pos_s;
  logic [NUM_REQ-1:0] ack_s;
  logic               out_req_s;

  // Descending loops let the lowest index (or nearest round-robin slot) overwrite earlier hits.
  always_comb begin
    err_found_s = 1'b0;
    err_idx_s   = '0;
    low_found_s = 1'b0;
    low_idx_s   = '0;
    rr_found_s  = 1'b0;
    rr_idx_s    = '0;
    rr_pos_s    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      err_found_s = err_found_s | (bus.req_valid[i] & bus.req_err[i]);
      err_idx_s   = (bus.req_valid[i] & bus.req_err[i]) ? PTR_W'(i) : err_idx_s;
      low_found_s = low_found_s | bus.req_valid[i];
      low_idx_s   = bus.req_valid[i] ? PTR_W'(i) : low_idx_s;
    end
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_pos_s   = (int'(last_grant_q) + k) % NUM_REQ;
      rr_found_s = rr_found_s | bus.req_valid[rr_pos_s];
      rr_idx_s   = bus.req_valid[rr_pos_s] ? PTR_W'(rr_pos_s) : rr_idx_s;
    end
    win_found_s = err_found_s | rr_found_s;
    win_idx_s   = err_found_s ? err_idx_s : rr_idx_s;
  end

  // State and datapath registers; reset outranks every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PTR_W'(NUM_REQ - 1);
      cur_err_q    <= 1'b0;
      msg_q        <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_err_q    <= cur_err_d;
      msg_q        <= msg_d;
      drop_q       <= drop_d;
    end
  end

  // Next-state logic: capture in IDLE, wait for ready in SEND, count drops in HALT.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_err_d    = cur_err_q;
    msg_d        = msg_q;
    drop_d       = drop_q;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          state_d      = SEND;
          last_grant_d = win_idx_s;
          cur_err_d    = bus.req_err[win_idx_s];
          msg_d        = bus.req_msg[int'(win_idx_s)*MSG_W +: MSG_W];
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (bus.uart_out_ready) begin
          state_d = cur_err_q ? HALT : IDLE;
        end else begin
          state_d = SEND;
        end
      end
      HALT: begin
        if (low_found_s && (drop_q != {DROP_W{1'b1}})) begin
          drop_d = drop_q + DROP_W'(1);
        end else begin
          drop_d = drop_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: acks in IDLE/HALT, send strobe follows ready in SEND.
  always_comb begin
    ack_s     = '0;
    out_req_s = 1'b0;
    case (state_q)
      IDLE:    ack_s = win_found_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s) : '0;
      SEND:    out_req_s = bus.uart_out_ready;
      HALT:    ack_s = low_found_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << low_idx_s) : '0;
      default: ack_s = '0;
    endcase
  end

  assign bus.req_ack      = reset ? '0 : ack_s;
  assign bus.uart_out_req = reset ? 1'b0 : out_req_s;
  assign bus.uart_out_msg = msg_q;
  assign bus.halted       = (state_q == HALT);
  assign bus.drop_count   = drop_q;
endmodule
